// File: rtl/mmio_pkg.sv
// Purpose: shared address map, UART state encoding and status bit positions for mmio_bus.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mmio_pkg;

  // Memory-mapped register addresses (word aligned; the bus ignores addr[1:0]).
  localparam logic [31:0] ADDR_TIMER_COUNT  = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_TIMER_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_TIMER_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_UART_TXDATA  = 32'hFFFF_0010;
  localparam logic [31:0] ADDR_UART_STATUS  = 32'hFFFF_0014;
  localparam logic [31:0] ADDR_LED          = 32'hFFFF_0020;

  // UART transmitter frame sequencing.
  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  // TIMER_STATUS bit positions.
  localparam int TSTAT_MATCH_BIT = 0;

  // UART_STATUS bit positions; occupancy occupies the field starting at COUNT_LSB.
  localparam int USTAT_FULL_BIT  = 0;
  localparam int USTAT_EMPTY_BIT = 1;
  localparam int USTAT_BUSY_BIT  = 2;
  localparam int USTAT_COUNT_LSB = 3;

endpackage

// File: rtl/mmio_bus_uart_tx.sv
// Purpose: 8N1 UART transmitter fed by a small byte FIFO.
// Latency: a push into an empty FIFO while idle starts the start bit on the following edge.
// Backpressure: pushes while full are dropped; software polls 'full' through UART_STATUS.
//
// Ports:
//   clk, reset      - core clock, synchronous active-high reset (aborts any frame, empties FIFO)
//   push, push_data - enqueue one byte per cycle
//   full, empty     - FIFO state
//   busy            - transmitter is somewhere inside a frame (state != IDLE)
//   count           - FIFO occupancy
//   tx              - registered serial output, idles high
module uart_tx
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CLK_W = $clog2(CLKS_PER_BIT);

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;

  uart_state_t      state;
  logic [CLK_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tx_q;

  logic push_ok;
  logic pop;
  logic bit_done;

  assign full  = (occ == CNT_W'(FIFO_DEPTH));
  assign empty = (occ == '0);
  assign busy  = (state != UART_IDLE);
  assign count = occ;
  assign tx    = tx_q;

  // 'empty' is registered, so a byte pushed at edge N is first seen by the
  // FSM in the following cycle and popped at edge N+1, never at edge N.
  assign push_ok  = push && !full;
  assign pop      = (state == UART_IDLE) && !empty;
  assign bit_done = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));

  // Storage carries no reset; pointer reset is what discards the contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave occupancy unchanged.
      case ({push_ok, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Frame sequencer. tx_q is loaded with the level of the phase being
  // entered, so the line changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= UART_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        UART_IDLE: begin
          tx_q    <= 1'b1;
          clk_cnt <= '0;
          bit_idx <= '0;
          if (pop) begin
            shreg <= fifo_mem[rd_ptr];
            state <= UART_START;
            tx_q  <= 1'b0;
          end
        end
        UART_START: begin
          if (bit_done) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= UART_DATA;
            tx_q    <= shreg[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        UART_DATA: begin
          if (bit_done) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= UART_STOP;
              tx_q  <= 1'b1;
            end else begin
              // LSB-first: next bit is always the one just above bit 0.
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        UART_STOP: begin
          tx_q <= 1'b1;
          if (bit_done) begin
            clk_cnt <= '0;
            state   <= UART_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state   <= UART_IDLE;
          clk_cnt <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mmio_bus.sv
// Purpose: MEM-stage data bus: decodes core accesses to data RAM, timer, UART TX and LED register.
// Latency: reads combinational (0 cycles); writes take effect at the next rising edge.
// Backpressure: none toward the core; UART bytes written while its FIFO is full are dropped.
//
// Ports:
//   clk, reset                       - core clock, synchronous active-high reset (RAM is not reset)
//   memwrite, memaddr, memwritedata  - one access per cycle from the core, memaddr[1:0] ignored
//   memreaddata                      - combinational read data for memaddr
//   uart_tx                          - 8N1 serial output, idles high
//   timer_irq                        - sticky compare-match flag (TIMER_STATUS bit 0)
//   led                              - LED register
module mmio_bus
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        uart_tx,
  output logic        timer_irq,
  output logic [7:0]  led
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0] ram [RAM_WORDS];

  logic [31:0] word_addr;
  logic        is_ram;
  logic [RAM_AW-1:0] ram_idx;

  logic wr_ram;
  logic wr_count;
  logic wr_cmp;
  logic wr_status;
  logic wr_txdata;
  logic wr_led;

  logic [31:0] timer_count;
  logic [31:0] timer_cmp;
  logic        timer_match;

  logic             u_full;
  logic             u_empty;
  logic             u_busy;
  logic [CNT_W-1:0] u_count;

  // ---------------------------------------------------------------- decode
  assign word_addr = {memaddr[31:2], 2'b00};
  assign is_ram    = (memaddr < RAM_BYTES);
  assign ram_idx   = memaddr[RAM_AW+1:2];

  // Register writes compare the full word address, so the RAM index bits of
  // an unmapped address can never alias into the RAM.
  assign wr_ram    = memwrite && is_ram;
  assign wr_count  = memwrite && (word_addr == ADDR_TIMER_COUNT);
  assign wr_cmp    = memwrite && (word_addr == ADDR_TIMER_CMP);
  assign wr_status = memwrite && (word_addr == ADDR_TIMER_STATUS);
  assign wr_txdata = memwrite && (word_addr == ADDR_UART_TXDATA);
  assign wr_led    = memwrite && (word_addr == ADDR_LED);

  // ---------------------------------------------------------------- RAM
  // No reset: contents survive a core reset. The combinational read below
  // sees the pre-edge contents, so same-cycle read-after-write returns old data.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_idx] <= memwritedata;
    end
  end

  // ---------------------------------------------------------------- timer + LED
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_count <= '0;
      timer_cmp   <= 32'hFFFF_FFFF;
      timer_match <= 1'b0;
      led         <= '0;
    end else begin
      // A software load overrides the free-running increment.
      if (wr_count) begin
        timer_count <= memwritedata;
      end else begin
        timer_count <= timer_count + 32'd1;
      end

      if (wr_cmp) begin
        timer_cmp <= memwritedata;
      end

      // Match is checked before the clear so a coincident match wins over W1C.
      if (timer_count == timer_cmp) begin
        timer_match <= 1'b1;
      end else if (wr_status && memwritedata[TSTAT_MATCH_BIT]) begin
        timer_match <= 1'b0;
      end

      if (wr_led) begin
        led <= memwritedata[7:0];
      end
    end
  end

  assign timer_irq = timer_match;

  // ---------------------------------------------------------------- UART
  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart_tx (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_txdata),
    .push_data (memwritedata[7:0]),
    .full      (u_full),
    .empty     (u_empty),
    .busy      (u_busy),
    .count     (u_count),
    .tx        (uart_tx)
  );

  // ---------------------------------------------------------------- read mux
  always_comb begin
    memreaddata = '0;
    if (is_ram) begin
      memreaddata = ram[ram_idx];
    end else begin
      case (word_addr)
        ADDR_TIMER_COUNT:  memreaddata = timer_count;
        ADDR_TIMER_CMP:    memreaddata = timer_cmp;
        ADDR_TIMER_STATUS: memreaddata[TSTAT_MATCH_BIT] = timer_match;
        ADDR_UART_STATUS: begin
          memreaddata[USTAT_FULL_BIT]            = u_full;
          memreaddata[USTAT_EMPTY_BIT]           = u_empty;
          memreaddata[USTAT_BUSY_BIT]            = u_busy;
          memreaddata[USTAT_COUNT_LSB +: CNT_W]  = u_count;
        end
        ADDR_LED:          memreaddata[7:0] = led;
        default:           memreaddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus.sv
module tb_mmio_bus;

  localparam int CPB = 4;

  localparam logic [31:0] A_COUNT  = 32'hFFFF_0000;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0010;
  localparam logic [31:0] A_USTAT  = 32'hFFFF_0014;
  localparam logic [31:0] A_LED    = 32'hFFFF_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        uart_tx;
  logic        timer_irq;
  logic [7:0]  led;

  int checks = 0;
  int passes = 0;

  logic [31:0] ram_m [int];
  logic [7:0]  rx_q [$];
  logic [7:0]  rx_byte;
  bit          rx_en = 1'b1;

  always #5 clk = ~clk;

  mmio_bus #(
    .RAM_WORDS    (1024),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .uart_tx      (uart_tx),
    .timer_irq    (timer_irq),
    .led          (led)
  );

  // UART_STATUS expected from its field values.
  function automatic logic [31:0] ustat(input bit f, input bit e, input bit b, input int n);
    return (32'(n) << 3) | (32'(b) << 2) | (32'(e) << 1) | 32'(f);
  endfunction

  // Write takes effect at the next edge; returns 1 time unit after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    memwrite     = 1'b1;
    memaddr      = a;
    memwritedata = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    memwrite = 1'b0;
    memaddr  = a;
    #1;
    d = memreaddata;
  endtask

  // Serial receiver: samples mid-bit on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          rx_byte[k] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) $display("FAIL rx_stop: line=%b required 1", uart_tx);
        else passes++;
        rx_q.push_back(rx_byte);
      end
    end
  end

  task automatic test_reset();
    logic [31:0] r;
    checks++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx); else passes++;
    checks++; if (timer_irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", timer_irq); else passes++;
    checks++; if (led !== 8'h00) $display("FAIL reset_led: got %h want 00", led); else passes++;
    bus_read(A_COUNT, r);
    checks++; if (r !== 32'h0) $display("FAIL reset_count: got %h want 0", r); else passes++;
    bus_read(A_CMP, r);
    checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL reset_cmp: got %h want ffffffff", r); else passes++;
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0) $display("FAIL reset_status: got %h want 0", r); else passes++;
    bus_read(A_USTAT, r);
    checks++; if (r !== ustat(0, 1, 0, 0)) $display("FAIL reset_ustat: got %h want %h", r, ustat(0, 1, 0, 0)); else passes++;
    bus_read(A_TXDATA, r);
    checks++; if (r !== 32'h0) $display("FAIL reset_txdata: got %h want 0", r); else passes++;
  endtask

  task automatic test_ram();
    logic [31:0] r, a, nv;
    int idx;
    bus_write(32'h40, 32'hDEAD_BEEF);
    ram_m[16] = 32'hDEAD_BEEF;
    bus_read(32'h40, r);
    checks++; if (r !== 32'hDEAD_BEEF) $display("FAIL ram_deadbeef: got %h want deadbeef", r); else passes++;
    bus_write(32'hFFC, 32'hCAFE_0FFC);
    ram_m[1023] = 32'hCAFE_0FFC;
    for (int i = 0; i < 12; i++) begin
      idx = $urandom_range(18, 1022);
      ram_m[idx] = $urandom;
      bus_write(32'(idx) * 4, ram_m[idx]);
    end
    foreach (ram_m[k]) begin
      a = (32'(k) * 4) | 32'($urandom_range(0, 3));
      bus_read(a, r);
      checks++; if (r !== ram_m[k]) $display("FAIL ram_readback[%0d]: got %h want %h", k, r, ram_m[k]); else passes++;
    end
    // Read-during-write to the same word returns the old contents.
    ram_m[17] = $urandom;
    bus_write(32'h44, ram_m[17]);
    nv = ~ram_m[17];
    memwrite = 1'b1; memaddr = 32'h44; memwritedata = nv;
    #1;
    checks++; if (memreaddata !== ram_m[17]) $display("FAIL ram_rdw_old: got %h want %h", memreaddata, ram_m[17]); else passes++;
    @(posedge clk); #1;
    memwrite = 1'b0;
    ram_m[17] = nv;
    bus_read(32'h44, r);
    checks++; if (r !== nv) $display("FAIL ram_rdw_new: got %h want %h", r, nv); else passes++;
    bus_read(32'h1000, r);
    checks++; if (r !== 32'h0) $display("FAIL ram_above_top: got %h want 0", r); else passes++;
  endtask

  task automatic test_led_unmapped();
    logic [31:0] r, v;
    bus_write(32'h8000_0040, 32'h1234_5678);
    bus_read(32'h8000_0000, r);
    checks++; if (r !== 32'h0) $display("FAIL unmapped_read: got %h want 0", r); else passes++;
    bus_read(32'h8000_0040, r);
    checks++; if (r !== 32'h0) $display("FAIL unmapped_read40: got %h want 0", r); else passes++;
    bus_read(32'h40, r);
    checks++; if (r !== ram_m[16]) $display("FAIL unmapped_alias: got %h want %h", r, ram_m[16]); else passes++;
    bus_read(32'hFFFF_0024, r);
    checks++; if (r !== 32'h0) $display("FAIL unmapped_ffff0024: got %h want 0", r); else passes++;
    bus_write(A_LED, 32'h1FF);
    checks++; if (led !== 8'hFF) $display("FAIL led_pin_1ff: got %h want ff", led); else passes++;
    bus_read(A_LED, r);
    checks++; if (r !== 32'h0000_00FF) $display("FAIL led_read_1ff: got %h want 000000ff", r); else passes++;
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      bus_write(A_LED, v);
      checks++; if (led !== v[7:0]) $display("FAIL led_pin_rand: got %h want %h", led, v[7:0]); else passes++;
      bus_read(A_LED, r);
      checks++; if (r !== {24'h0, v[7:0]}) $display("FAIL led_read_rand: got %h want %h", r, {24'h0, v[7:0]}); else passes++;
    end
  endtask

  task automatic test_timer();
    logic [31:0] r, cmp, k;
    logic [31:0] cmps [2];
    logic [31:0] ks [2];
    cmps[0] = 32'd20; ks[0] = 32'd10;
    cmps[1] = $urandom; ks[1] = $urandom_range(2, 40);
    for (int t = 0; t < 2; t++) begin
      cmp = cmps[t]; k = ks[t];
      bus_write(A_COUNT, cmp + 32'd100);
      bus_write(A_CMP, cmp);
      bus_write(A_STATUS, 32'h1);
      bus_read(A_CMP, r);
      checks++; if (r !== cmp) $display("FAIL timer_cmp_read: got %h want %h", r, cmp); else passes++;
      bus_write(A_COUNT, cmp - k);
      bus_read(A_COUNT, r);
      checks++; if (r !== cmp - k) $display("FAIL timer_count_load: got %h want %h", r, cmp - k); else passes++;
      // Match in the cycle COUNT==CMP (k cycles after load) shows from the next one.
      for (int i = 0; i <= int'(k) + 3; i++) begin
        if (i > 0) begin
          @(posedge clk); #1;
        end
        checks++;
        if (timer_irq !== (i >= int'(k) + 1)) $display("FAIL timer_irq_cycle%0d: got %b want %b", i, timer_irq, (i >= int'(k) + 1));
        else passes++;
      end
    end
    // Plain W1C clears.
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0) $display("FAIL timer_w1c: got %h want 0", r); else passes++;
    // W1C in the same cycle as a fresh match: the match wins.
    bus_write(A_COUNT, cmp);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h1 || timer_irq !== 1'b1) $display("FAIL timer_set_wins: got %h irq %b want 1", r, timer_irq); else passes++;
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, r);
    checks++; if (r !== 32'h0) $display("FAIL timer_w1c_after: got %h want 0", r); else passes++;
    // Wrap.
    bus_write(A_COUNT, 32'hFFFF_FFFF);
    bus_read(A_COUNT, r);
    checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL timer_wrap_pre: got %h want ffffffff", r); else passes++;
    @(posedge clk); #1;
    bus_read(A_COUNT, r);
    checks++; if (r !== 32'h0) $display("FAIL timer_wrap_post: got %h want 0", r); else passes++;
  endtask

  task automatic test_uart_frame(input logic [7:0] d);
    logic [31:0] r;
    logic [9:0]  fr;
    logic        exp_tx;
    fr = {1'b1, d, 1'b0};
    bus_write(A_TXDATA, {24'h0, d});
    bus_read(A_USTAT, r);
    checks++; if (r !== ustat(0, 0, 0, 1)) $display("FAIL frame_queued_ustat: got %h want %h", r, ustat(0, 0, 0, 1)); else passes++;
    for (int j = 1; j <= 10 * CPB + 1; j++) begin
      @(posedge clk); #1;
      exp_tx = (j <= 10 * CPB) ? fr[(j - 1) / CPB] : 1'b1;
      checks++; if (uart_tx !== exp_tx) $display("FAIL frame_%h_cycle%0d: got %b want %b", d, j, uart_tx, exp_tx); else passes++;
      if (j == 1 || j == 10 * CPB || j == 10 * CPB + 1) begin
        bus_read(A_USTAT, r);
        checks++;
        if (r !== ustat(0, 1, (j <= 10 * CPB), 0))
          $display("FAIL frame_busy_cycle%0d: got %h want %h", j, r, ustat(0, 1, (j <= 10 * CPB), 0));
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [7:0]  b [6];
    rx_q.delete();
    for (int k = 0; k < 6; k++) begin
      b[k] = 8'($urandom);
      bus_write(A_TXDATA, {24'h0, b[k]});
    end
    // First byte is in flight, the next four fill the FIFO, the sixth is dropped.
    bus_read(A_USTAT, r);
    checks++; if (r !== ustat(1, 0, 1, 4)) $display("FAIL b2b_ustat: got %h want %h", r, ustat(1, 0, 1, 4)); else passes++;
    for (int t = 0; t < 400 && rx_q.size() < 5; t++) @(posedge clk);
    repeat (60) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 5) $display("FAIL b2b_frames: got %0d want 5", rx_q.size()); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx_q.size() <= k) $display("FAIL b2b_byte%0d: got none want %h", k, b[k]);
      else if (rx_q[k] !== b[k]) $display("FAIL b2b_byte%0d: got %h want %h", k, rx_q[k], b[k]);
      else passes++;
    end
    bus_read(A_USTAT, r);
    checks++; if (r !== ustat(0, 1, 0, 0)) $display("FAIL b2b_drained: got %h want %h", r, ustat(0, 1, 0, 0)); else passes++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] r, a, v;
    int lows;
    rx_en = 1'b0;
    a = 32'($urandom_range(200, 1000)) * 4;
    v = $urandom;
    bus_write(a, v);
    bus_write(A_LED, 32'h5A);
    bus_write(A_TXDATA, 32'h3C);
    bus_write(A_TXDATA, 32'hC3);
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (uart_tx !== 1'b1) $display("FAIL rst_mid_tx: got %b want 1", uart_tx); else passes++;
    checks++; if (led !== 8'h00) $display("FAIL rst_mid_led: got %h want 00", led); else passes++;
    checks++; if (timer_irq !== 1'b0) $display("FAIL rst_mid_irq: got %b want 0", timer_irq); else passes++;
    bus_read(A_USTAT, r);
    checks++; if (r !== ustat(0, 1, 0, 0)) $display("FAIL rst_mid_ustat: got %h want %h", r, ustat(0, 1, 0, 0)); else passes++;
    bus_read(a, r);
    checks++; if (r !== v) $display("FAIL rst_mid_ram: got %h want %h", r, v); else passes++;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) $display("FAIL rst_mid_discard: got %0d non-idle samples want 0", lows); else passes++;
    rx_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    memwrite     = 1'b0;
    memaddr      = 32'h0;
    memwritedata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_ram();
    test_led_unmapped();
    test_timer();
    test_uart_frame(8'hA5);
    test_uart_frame(8'($urandom));
    test_back_to_back();
    test_reset_midframe();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mmio_bus.md
# mmio_bus

Data-side memory subsystem that sits directly downstream of the pipelined MIPS core's MEM-stage port (`memwrite`, `memaddr`, `memwritedata`, `memreaddata`). It decodes each access and routes it to one of three targets: a word-addressed data RAM, a free-running timer with a compare, or an 8N1 UART transmitter with a 4-entry FIFO. Reads are combinational because the core samples `memreaddata` in the same MEM cycle; all state updates happen on the clock edge.

## Interface
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words (power of two).
- `CLKS_PER_BIT`, 16: UART bit period in clocks (≥2).
- `FIFO_DEPTH`, 4: UART TX FIFO entries (power of two).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `memwrite`  in  1  write strobe, one access per cycle.
- `memaddr`  in  32  byte address, word-aligned; `[1:0]` ignored.
- `memwritedata`  in  32  store data.
- `memreaddata`  out  32  combinational read data for `memaddr`.
- `uart_tx`  out  1  serial line, idles high.
- `timer_irq`  out  1  equals TIMER_STATUS bit 0.
- `led`  out  8  LED register.

## Operation
- Address map:
  - RAM: `memaddr < RAM_WORDS*4`, indexed by `memaddr[log2(RAM_WORDS)+1:2]`.
  - `0xFFFF_0000` TIMER_COUNT (RW).
  - `0xFFFF_0004` TIMER_CMP (RW).
  - `0xFFFF_0008` TIMER_STATUS (bit0 sticky match; write 1 to clear).
  - `0xFFFF_0010` UART_TXDATA (write enqueues `memwritedata[7:0]`; reads 0).
  - `0xFFFF_0014` UART_STATUS: bit0 full, bit1 empty, bit2 busy (state≠IDLE), bits[5:3] occupancy.
  - `0xFFFF_0020` LED (RW, bits[7:0]).
- Unmapped addresses read 0; writes to them are ignored.
- RAM: written at the edge when `memwrite`. It has no reset. A read in the same cycle as a write to the same word returns the old contents.
- Timer:
  - COUNT increments by 1 every cycle, wrapping `0xFFFF_FFFF→0`.
  - A write to COUNT loads `memwritedata` and takes precedence over the increment.
  - If current COUNT == CMP, status bit0 sets at the next edge.
  - If a set and a W1C clear occur in the same cycle, the set wins.
- UART TX FSM, states IDLE→START→DATA→STOP→IDLE:
  - IDLE with FIFO non-empty: pop the head into the shift register, go to START.
  - START drives 0 for `CLKS_PER_BIT` cycles.
  - DATA sends 8 bits LSB-first, `CLKS_PER_BIT` cycles each.
  - STOP drives 1 for `CLKS_PER_BIT` cycles, then returns to IDLE.
  - `uart_tx` is 1 in IDLE and STOP.
- FIFO boundaries:
  - A write to TXDATA while full is dropped silently; occupancy is unchanged.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - A push into an empty FIFO while the FSM is IDLE pops on the following edge, never the same edge.

## Timing
- Reset values:
  - `memreaddata` follows the address.
  - COUNT=0, CMP=`0xFFFF_FFFF`, STATUS=0, `timer_irq`=0, `led`=0.
  - FIFO empty, FSM IDLE, `uart_tx`=1, bit/clock counters 0.
- Reset during a UART frame aborts it: `uart_tx` returns to 1 after that edge and FIFO contents are discarded. RAM contents are preserved.
- Read latency 0 cycles; write latency 1 edge. A register write at edge N is visible to a read in cycle N+1.
- TXDATA write at edge N:
  - FSM enters START at edge N+1; `uart_tx`=0 from N+1.
  - Frame = 10·`CLKS_PER_BIT` cycles; IDLE is re-entered at N+1+10·`CLKS_PER_BIT`.
  - A queued byte starts one cycle later (one-cycle IDLE gap between frames).
- Match is registered: count reaching CMP in cycle C raises `timer_irq` from cycle C+1.

## Structure
- Package `mmio_pkg` holds:
  - the address constants (`ADDR_TIMER_COUNT` … `ADDR_LED`);
  - the UART state enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`);
  - the status bit positions.
- Sub-module `uart_tx` contains the FIFO, FSM and bit counters. Its ports are `push`, `push_data[7:0]`, `full`, `empty`, `busy`, `count`, `tx`.
- Address decode, RAM, timer and LED live in `mmio_bus`.

## Test plan
- Reset, then RAM write `0x0000_0040←0xDEADBEEF`, then read the same address → `0xDEADBEEF`. Read `0x0000_0044` in the same cycle as a write to it → old value.
- Write CMP=20 then COUNT=10 → `timer_irq` rises exactly 11 cycles after the COUNT write. W1C of STATUS in the same cycle as a fresh match → bit stays 1.
- `CLKS_PER_BIT`=4, write TXDATA=`0xA5`:
  - `uart_tx` is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop 1.
  - `busy` is low 40 cycles after entering START.
- Write 6 bytes back-to-back while idle:
  - one byte is popped immediately, four are queued, the sixth is dropped;
  - STATUS reads full=1, count=4;
  - exactly 5 frames appear on `uart_tx`.
- Assert `reset` mid-frame → `uart_tx`=1, STATUS empty=1 busy=0, `led`=0 next cycle; a previously written RAM word still reads back.
- Read unmapped `0x8000_0000` → 0. Write LED=`0x1FF` → `led`=`0xFF`; reading LED returns `0x0000_00FF`.
